// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions for the transmit serializer and the decoder's golden checks.
// Frame width grows to 8 bits (SECDED) when HAMMING_PARITY_EXT_EN is defined.
package hamming_pkg;

`ifdef HAMMING_PARITY_EXT_EN
    localparam int unsigned CW_W = 8;
`else
    localparam int unsigned CW_W = 7;
`endif

    localparam logic [2:0] LAST_IDX = 3'(CW_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    // Bit i of the result holds Hamming position i+1, so a decoder syndrome maps directly onto it.
    function automatic logic [6:0] hamming74_encode(input logic [3:0] d);
        logic p1;
        logic p2;
        logic p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

endpackage

// File: rtl/hamming_tx_serializer_enc.sv
// Combinational nibble -> codeword encoder; appends the overall-parity bit when
// HAMMING_PARITY_EXT_EN is defined.
module hamming74_enc
    import hamming_pkg::*;
(
    input  logic [3:0]      data,
    output logic [CW_W-1:0] codeword
);

    logic [6:0] base;

    always_comb begin
        base = hamming74_encode(data);
`ifdef HAMMING_PARITY_EXT_EN
        codeword = {^base, base};
`else
        codeword = base;
`endif
    end

endmodule

// File: rtl/hamming_tx_serializer.sv
// Hamming(7,4) encoder with one-entry codeword buffer and LSB-first serializer with framing strobes.
// Define HAMMING_PARITY_EXT_EN for 8-bit SECDED frames (overall parity sent last).
module hamming_tx_serializer
    import hamming_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       sout,
    output logic       sout_valid,
    output logic       sout_first,
    output logic       sout_last,
    output logic       busy
);

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t          state;
    logic            buf_full;
    logic [CW_W-1:0] buf_cw;
    logic [CW_W-1:0] sreg;
    logic [CW_W-1:0] enc_cw;
    logic [2:0]      bit_cnt;
    logic [3:0]      gap_cnt;
    logic            take;
    logic            load;
    logic            active_next;
    logic            buf_full_next;

    hamming74_enc u_enc (
        .data     (in_data),
        .codeword (enc_cw)
    );

    // load: the shifter is free at this edge and a buffered codeword is waiting.
    always_comb begin
        load        = 1'b0;
        active_next = 1'b0;
        case (state)
            IDLE:  load = buf_full;
            SHIFT: begin
                if (bit_cnt != LAST_IDX || GAP_CYCLES != 0) active_next = 1'b1;
                else                                         load        = buf_full;
            end
            GAP: begin
                if (gap_cnt != GAP_LAST) active_next = 1'b1;
                else                     load        = buf_full;
            end
            default: load = 1'b0;
        endcase
        take          = in_valid && in_ready;
        buf_full_next = take || (buf_full && !load);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            buf_full   <= 1'b0;
            buf_cw     <= '0;
            sreg       <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sout_first <= 1'b0;
            sout_last  <= 1'b0;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sout_first <= 1'b0;
            sout_last  <= 1'b0;
            case (state)
                IDLE: state <= IDLE;
                SHIFT: begin
                    if (bit_cnt != LAST_IDX) begin
                        sout       <= sreg[0];
                        sreg       <= sreg >> 1;
                        bit_cnt    <= bit_cnt + 3'd1;
                        sout_valid <= 1'b1;
                        sout_last  <= (bit_cnt == LAST_IDX - 3'd1);
                    end else if (GAP_CYCLES != 0) begin
                        state   <= GAP;
                        gap_cnt <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                GAP: begin
                    if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + 4'd1;
                    else                     state   <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Starting a frame overrides the end-of-frame transition above (back-to-back reload).
            if (load) begin
                state      <= SHIFT;
                sreg       <= buf_cw >> 1;
                sout       <= buf_cw[0];
                sout_valid <= 1'b1;
                sout_first <= 1'b1;
                bit_cnt    <= '0;
            end

            if (take) buf_cw <= enc_cw;
            buf_full <= buf_full_next;
            in_ready <= !buf_full_next;
            busy     <= buf_full_next || active_next || load;
        end
    end

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Self-checking bench: cycle-accurate timeline model for GAP_CYCLES=0, directed gap check on a
// second instance with GAP_CYCLES=3, and a syndrome-decode loopback over all nibbles.
module tb_hamming_tx_serializer;

`ifdef HAMMING_PARITY_EXT_EN
    localparam int N = 8;
`else
    localparam int N = 7;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready, sout, sout_valid, sout_first, sout_last, busy;
    logic [3:0] g_in_data;
    logic       g_in_valid;
    logic       g_in_ready, g_sout, g_sout_valid, g_sout_first, g_sout_last, g_busy;

    always #5 clk = ~clk;

    hamming_tx_serializer #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sout(sout), .sout_valid(sout_valid), .sout_first(sout_first), .sout_last(sout_last),
        .busy(busy)
    );

    hamming_tx_serializer #(.GAP_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .in_data(g_in_data), .in_valid(g_in_valid), .in_ready(g_in_ready),
        .sout(g_sout), .sout_valid(g_sout_valid), .sout_first(g_sout_first),
        .sout_last(g_sout_last), .busy(g_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_end = -1000;

    typedef struct packed {
        logic v;
        logic b;
        logic f;
        logic l;
    } slot_t;

    slot_t exp_slot[int];
    bit    exp_busy[int];
    bit    exp_nrdy[int];

    logic [7:0] frames[$];
    logic [7:0] m_bits;
    int         m_n;
    logic [7:0] g_frames[$];
    int         g_gaps[$];
    logic [7:0] g_bits;
    int         g_n;
    int         g_idle;

    // Codeword from positional Hamming rules: data in non-power-of-two positions,
    // parity at position 2^j covers every position with bit j set.
    function automatic logic [7:0] ref_cw(input logic [3:0] d);
        logic [7:0] cw;
        int         dpos[4];
        logic       p;
        dpos = '{3, 5, 6, 7};
        cw   = '0;
        for (int i = 0; i < 4; i++) cw[dpos[i]-1] = d[i];
        for (int j = 0; j < 3; j++) begin
            p = 1'b0;
            for (int pos = 1; pos <= 7; pos++)
                if (((pos >> j) & 1) == 1 && pos != (1 << j)) p ^= cw[pos-1];
            cw[(1 << j) - 1] = p;
        end
`ifdef HAMMING_PARITY_EXT_EN
        cw[7] = ^cw[6:0];
`endif
        return cw;
    endfunction

    function automatic int syndrome(input logic [6:0] r);
        int s = 0;
        for (int pos = 1; pos <= 7; pos++) if (r[pos-1]) s ^= pos;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            m_n = 0;
        end else if (sout_valid) begin
            if (sout_first) begin m_n = 0; m_bits = '0; end
            if (m_n < 8) m_bits[m_n] = sout;
            m_n++;
            if (sout_last) frames.push_back(m_bits);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            g_idle = -1;
            g_n    = 0;
        end else if (g_sout_valid) begin
            if (g_sout_first) begin
                if (g_idle >= 0) g_gaps.push_back(g_idle);
                g_n    = 0;
                g_bits = '0;
            end
            if (g_n < 8) g_bits[g_n] = g_sout;
            g_n++;
            if (g_sout_last) begin g_frames.push_back(g_bits); g_idle = 0; end
        end else if (g_idle >= 0) begin
            g_idle++;
        end
    end

    // One clock: update the timeline model at the edge, then compare dut0 at the falling edge.
    task automatic tick();
        bit         prev_rdy;
        bit         rst_edge;
        int         s;
        logic [7:0] cw;
        slot_t      e;
        prev_rdy = !exp_nrdy.exists(cyc);
        @(posedge clk);
        cyc++;
        rst_edge = rst;
        if (rst) begin
            exp_slot.delete();
            exp_busy.delete();
            exp_nrdy.delete();
            last_end = -1000;
        end else if (in_valid && prev_rdy) begin
            s  = (cyc + 1 > last_end + 1) ? cyc + 1 : last_end + 1;
            cw = ref_cw(in_data);
            for (int i = 0; i < N; i++)
                exp_slot[s+i] = '{v: 1'b1, b: cw[i], f: (i == 0), l: (i == N - 1)};
            for (int c = cyc; c < s; c++) exp_nrdy[c] = 1'b1;
            for (int c = cyc; c < s + N; c++) exp_busy[c] = 1'b1;
            last_end = s + N - 1;
        end
        @(negedge clk);
        e = exp_slot.exists(cyc) ? exp_slot[cyc] : '0;
        chk("sout_valid", 8'(sout_valid), 8'(e.v));
        chk("sout_first", 8'(sout_first), 8'(e.f));
        chk("sout_last", 8'(sout_last), 8'(e.l));
        chk("in_ready", 8'(in_ready), 8'(!exp_nrdy.exists(cyc)));
        chk("busy", 8'(busy), 8'(exp_busy.exists(cyc)));
        if (e.v || rst_edge) chk("sout", 8'(sout), 8'(e.b));
    endtask

    task automatic send(input logic [3:0] d);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 30 && !ok; t++) begin
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        in_data  = 4'bxxxx;
        n_checks++;
        assert (ok) else begin n_fail++; $error("FAIL send_timeout observed=0 expected=1"); end
    endtask

    task automatic g_send(input logic [3:0] d);
        bit ok = 1'b0;
        g_in_valid = 1'b1;
        g_in_data  = d;
        for (int t = 0; t < 30 && !ok; t++) begin
            ok = g_in_ready;
            tick();
        end
        g_in_valid = 1'b0;
        n_checks++;
        assert (ok) else begin n_fail++; $error("FAIL g_send_timeout observed=0 expected=1"); end
    endtask

    task automatic wait_frames(input int n);
        for (int t = 0; t < 200 && frames.size() < n; t++) tick();
        chk("frame_count", 8'(frames.size() >= n), 8'd1);
    endtask

    initial begin
        logic [3:0] a, b, c;
        int         f0;
        logic [7:0] fr;
        logic [6:0] r;
        logic [6:0] corr;
        int         s;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; g_in_valid = 1'b0; g_in_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single frame, known codeword.
        f0 = frames.size();
        send(4'b1011);
        wait_frames(f0 + 1);
        if (frames.size() > f0) chk("frame_1011", frames[f0], 8'b01010101);

        // Back-to-back frames; contiguity checked cycle-by-cycle by the timeline model.
        f0 = frames.size();
        send(4'b0000); send(4'b1111); send(4'b0001);
        wait_frames(f0 + 3);
        if (frames.size() >= f0 + 3) begin
            chk("frame_0000", frames[f0], 8'h00);
`ifdef HAMMING_PARITY_EXT_EN
            chk("frame_1111", frames[f0+1], 8'hFF);
            chk("frame_0001", frames[f0+2], 8'b10000111);
`else
            chk("frame_1111", frames[f0+1], 8'h7F);
            chk("frame_0001", frames[f0+2], 8'b00000111);
`endif
        end

        // Reset during bit 3 with the buffer full.
        repeat (3) tick();
        f0 = frames.size();
        a = 4'hA; b = 4'h5; c = 4'h3;
        send(a); send(b);
        tick(); tick();
        chk("mid_ready_low", 8'(in_ready), 8'd0);
        rst = 1'b1;
        tick();
        chk("rst_ready", 8'(in_ready), 8'd1);
        chk("rst_valid", 8'(sout_valid), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        rst = 1'b0;
        tick();
        send(c);
        wait_frames(f0 + 1);
        repeat (12) tick();
        chk("no_resume", 8'(frames.size()), 8'(f0 + 1));
        if (frames.size() > f0) chk("after_rst_frame", frames[f0], ref_cw(c));

        // Loopback: every nibble, every single-bit error position.
        f0 = frames.size();
        for (int i = 0; i < 16; i++) send(4'(i));
        wait_frames(f0 + 16);
        for (int i = 0; i < 16 && f0 + i < frames.size(); i++) begin
            fr = frames[f0+i];
            chk("lb_clean_syn", 8'(syndrome(fr[6:0])), 8'd0);
`ifdef HAMMING_PARITY_EXT_EN
            chk("lb_ext_parity", 8'(fr[7]), 8'(^fr[6:0]));
`endif
            for (int p = 0; p < 7; p++) begin
                r    = fr[6:0] ^ (7'd1 << p);
                s    = syndrome(r);
                chk("lb_is_error", 8'(s != 0), 8'd1);
                chk("lb_position", 8'(s), 8'(p + 1));
                corr = (s >= 1 && s <= 7) ? (r ^ (7'd1 << (s - 1))) : r;
                chk("lb_nibble", {4'd0, corr[6], corr[5], corr[4], corr[2]}, 8'(i));
            end
        end

        // Inter-frame gap on the GAP_CYCLES=3 instance.
        rst = 1'b1; tick(); tick();
        g_frames.delete(); g_gaps.delete();
        rst = 1'b0; tick();
        a = 4'($urandom); b = 4'($urandom);
        g_send(a); g_send(b);
        for (int t = 0; t < 80 && g_frames.size() < 2; t++) tick();
        chk("gap_frames", 8'(g_frames.size()), 8'd2);
        if (g_frames.size() >= 2) begin
            chk("gap_frame0", g_frames[0], ref_cw(a));
            chk("gap_frame1", g_frames[1], ref_cw(b));
        end
        chk("gap_seen", 8'(g_gaps.size()), 8'd1);
        if (g_gaps.size() > 0) chk("gap_len", 8'(g_gaps[0]), 8'd3);

        // Randomized traffic with occasional resets.
        for (int t = 0; t < 400; t++) begin
            rst      = ($urandom_range(0, 99) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = in_valid ? 4'($urandom) : 4'bxxxx;
            tick();
        end
        rst = 1'b0; in_valid = 1'b0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
